// File: rtl/flash_pkg.sv
// Shared definitions for the flash word fetch block.
//   ADDR_W  : flash byte address width
//   WORD_W  : width of the packed output word
//   state_e : sequencer states of flash_word_fetch
package flash_pkg;

  localparam int ADDR_W = 24;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_PUSH,
    ST_STALL
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word and an occupancy count.
// Ports:
//   clock, reset_n        : rising-edge clock, async active-low reset
//   push_i, push_data_i   : write request and data (ignored when full)
//   pop_i                 : read request (ignored when empty)
//   count_o               : number of stored entries
//   valid_o, head_o       : registered "not empty" flag and head entry
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push_i && (count_q != FULL_C);
    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
    valid_d = (count_d != '0);
    // The next head is the entry being written this cycle when the FIFO
    // drains down to it (or was empty); otherwise it is already in memory.
    if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule

// File: rtl/flash_word_fetch.sv
// Block reader in front of spi_wrapper: turns one (start address, word count)
// command into byte-read requests, packs returned bytes little-endian into
// 32-bit words and queues them in a FIFO for the consumer.
// Ports:
//   clock, reset_n                : rising-edge clock, async active-low reset
//   start_i, start_addr_i,
//   word_count_i                  : command strobe and operands
//   busy_o, done_o                : command in progress / completion pulse
//   flash_valid_o, flash_addr_o,
//   flash_ready_i, flash_rdata_i  : byte-read handshake with spi_wrapper
//   word_valid_o, word_data_o,
//   word_ready_i                  : output word stream (FIFO head)
module flash_word_fetch
  import flash_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [15:0]       word_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              flash_valid_o,
  output logic [ADDR_W-1:0] flash_addr_o,
  input  logic              flash_ready_i,
  input  logic [7:0]        flash_rdata_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_data_o,
  input  logic              word_ready_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_C      = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_SLOT_C = CNT_W'(FIFO_DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0] lanes_q, lanes_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              fvalid_q, fvalid_d;

  logic              push;
  logic              pop;
  logic              slot_free;
  logic [CNT_W-1:0]  fifo_count;

  assign pop       = word_valid_o & word_ready_i;
  assign slot_free = (fifo_count < FULL_C);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d = start_addr_i;
          cnt_d  = word_count_i;
          idx_d  = 2'd0;
          if (word_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = slot_free ? ST_ISSUE : ST_STALL;
          end
        end
      end
      ST_ISSUE: begin
        if (flash_ready_i) begin
          lanes_d[{idx_q, 3'b000} +: 8] = flash_rdata_i;
          addr_d = addr_q + ADDR_W'(1);
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_PUSH;
            // done_o is registered, so it is raised on entry to the last PUSH
            done_d  = (cnt_q == 16'd1);
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_ISSUE;
      end
      ST_PUSH: begin
        push  = 1'b1;
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = ST_IDLE;
        end else if ((fifo_count == LAST_SLOT_C) && !pop) begin
          // this push takes the last free slot: no room to reserve the next word
          state_d = ST_STALL;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_STALL: begin
        if (slot_free) begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d   = (state_d != ST_IDLE);
    fvalid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      lanes_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      lanes_q  <= lanes_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign flash_valid_o = fvalid_q;
  assign flash_addr_o  = addr_q;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (lanes_q),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .valid_o     (word_valid_o),
    .head_o      (word_data_o)
  );

endmodule

// File: tb/tb_flash_word_fetch.sv
// Self-checking bench for flash_word_fetch: a flash responder with random
// latency and stray ready pulses, a consumer with selectable back-pressure,
// and a reference model that derives expected words and request addresses
// directly from the flash contents and the command operands.
module tb_flash_word_fetch;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [23:0] start_addr_i;
  logic [15:0] word_count_i;
  logic        busy_o;
  logic        done_o;
  logic        flash_valid_o;
  logic [23:0] flash_addr_o;
  logic        flash_ready_i;
  logic [7:0]  flash_rdata_i;
  logic        word_valid_o;
  logic [31:0] word_data_o;
  logic        word_ready_i;

  flash_word_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start_i       (start_i),
    .start_addr_i  (start_addr_i),
    .word_count_i  (word_count_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .flash_valid_o (flash_valid_o),
    .flash_addr_o  (flash_addr_o),
    .flash_ready_i (flash_ready_i),
    .flash_rdata_i (flash_rdata_i),
    .word_valid_o  (word_valid_o),
    .word_data_o   (word_data_o),
    .word_ready_i  (word_ready_i)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int          rdy_mode   = 0;   // 0: always ready, 1: random, 2: hold off
  bit          spur_en    = 1'b0;
  int          max_lat    = 0;
  int          resp_lat   = 0;
  int          done_cnt   = 0;
  int          fv_cycles  = 0;
  logic [23:0] req_q[$];
  logic [31:0] got_q[$];

  typedef struct {
    logic [23:0] addr;
    int          n;
    int          mode;
    bit          restart;
    int          lat;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[4];

  // Flash contents: every byte is a function of its own address.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16];
  endfunction

  function automatic logic [31:0] model_word(input logic [23:0] base, input int w);
    logic [31:0] word;
    for (int b = 0; b < 4; b++) begin
      word[8*b +: 8] = flash_byte(base + 24'(4*w + b));
    end
    return word;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Flash responder: answers each request after a random delay, and may
  // raise a stray ready pulse while no request is pending.
  initial begin
    flash_ready_i = 1'b0;
    flash_rdata_i = 8'h00;
    forever begin
      @(negedge clock);
      flash_ready_i = 1'b0;
      if (flash_valid_o) begin
        fv_cycles++;
        if (resp_lat == 0) begin
          flash_ready_i = 1'b1;
          flash_rdata_i = flash_byte(flash_addr_o);
          req_q.push_back(flash_addr_o);
          resp_lat = $urandom_range(max_lat, 0);
        end else begin
          resp_lat--;
        end
      end else if (spur_en && ($urandom_range(3, 0) == 0)) begin
        flash_ready_i = 1'b1;
        flash_rdata_i = 8'hA5;
      end
    end
  end

  // Consumer and done monitor.
  initial begin
    word_ready_i = 1'b0;
    forever begin
      @(negedge clock);
      case (rdy_mode)
        0:       word_ready_i = 1'b1;
        1:       word_ready_i = ($urandom_range(1, 0) == 1);
        default: word_ready_i = 1'b0;
      endcase
      if (word_valid_o && word_ready_i && reset_n) got_q.push_back(word_data_o);
      if (done_o) done_cnt++;
    end
  end

  task automatic start_cmd(input logic [23:0] addr, input int n);
    req_q.delete();
    got_q.delete();
    done_cnt     = 0;
    start_addr_i = addr;
    word_count_i = 16'(n);
    start_i      = 1'b1;
    step();
    start_i      = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int n);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      step();
      cyc++;
    end
    check({tag, "_busy_done_at_end"}, 32'({busy_o, done_o}), 32'h3);
    step();
    check({tag, "_busy_done_after"}, 32'({busy_o, done_o}), 32'h0);
    cyc = 0;
    while ((got_q.size() < n || word_valid_o) && cyc < 500) begin
      step();
      cyc++;
    end
    repeat (4) step();
  endtask

  task automatic verify(input string tag, input logic [23:0] addr, input int n);
    int errs;
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_req_count"}, 32'(req_q.size()), 32'(4 * n));
    errs = 0;
    for (int i = 0; i < req_q.size(); i++) begin
      if (req_q[i] !== addr + 24'(i)) errs++;
    end
    check({tag, "_req_addr_errs"}, 32'(errs), 32'd0);
    check({tag, "_word_count"}, 32'(got_q.size()), 32'(n));
    errs = 0;
    for (int i = 0; i < got_q.size() && i < n; i++) begin
      if (got_q[i] !== model_word(addr, i)) errs++;
    end
    check({tag, "_word_errs"}, 32'(errs), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [23:0] addr, input int n,
                         input int mode, input bit restart, input int lat);
    rdy_mode = mode;
    max_lat  = lat;
    start_cmd(addr, n);
    check({tag, "_busy_rise"}, 32'(busy_o), 32'd1);
    check({tag, "_fvalid_rise"}, 32'(flash_valid_o), 32'd1);
    if (restart) begin
      step();
      step();
      start_addr_i = addr ^ 24'h5A5A5A;
      word_count_i = 16'(n + 3);
      start_i      = 1'b1;
      step();
      start_i      = 1'b0;
    end
    finish_cmd(tag, n);
    verify(tag, addr, n);
  endtask

  initial begin
    int cyc;
    int fv0;
    logic [23:0] raddr;
    int rn;

    vecs[0] = '{24'h000000, 2, 0, 1'b0, 0, 32'h03020100, 32'h07060504};
    vecs[1] = '{24'hFFFFFE, 1, 0, 1'b0, 1, 32'h0100FFFE, 32'h0100FFFE};
    vecs[2] = '{24'h123456, 5, 1, 1'b1, 2, 32'h7F7E7170, 32'h4F4E4140};
    vecs[3] = '{24'h00FFFC, 3, 1, 1'b0, 3, 32'h00010203, 32'h06070405};

    reset_n      = 1'b0;
    start_i      = 1'b0;
    start_addr_i = '0;
    word_count_i = '0;
    repeat (3) step();
    check("reset_ctrl", 32'({busy_o, done_o, flash_valid_o, word_valid_o}), 32'h0);
    check("reset_addr", 32'(flash_addr_o), 32'h0);
    check("reset_data", word_data_o, 32'h0);
    reset_n = 1'b1;
    step();

    // Table-driven commands.
    for (int v = 0; v < 4; v++) begin
      run_cmd($sformatf("vec%0d", v), vecs[v].addr, vecs[v].n, vecs[v].mode,
              vecs[v].restart, vecs[v].lat);
      check($sformatf("vec%0d_first", v),
            (got_q.size() > 0) ? got_q[0] : 32'hDEADBEEF, vecs[v].first);
      check($sformatf("vec%0d_last", v),
            (got_q.size() > 0) ? got_q[got_q.size()-1] : 32'hDEADBEEF, vecs[v].last);
    end

    // Zero-length command.
    rdy_mode = 0;
    fv0      = fv_cycles;
    start_cmd(24'h000100, 0);
    check("zero_done_pulse", 32'({busy_o, done_o}), 32'h1);
    repeat (5) step();
    check("zero_done_count", 32'(done_cnt), 32'd1);
    check("zero_no_request", 32'(fv_cycles - fv0), 32'd0);
    check("zero_busy", 32'(busy_o), 32'd0);

    // FIFO back-pressure: four words buffered, then stall until released.
    rdy_mode = 2;
    max_lat  = 1;
    spur_en  = 1'b1;
    start_cmd(24'h000200, 6);
    cyc = 0;
    while (req_q.size() < 16 && cyc < 2000) begin
      step();
      cyc++;
    end
    repeat (20) step();
    check("stall_req_count", 32'(req_q.size()), 32'd16);
    check("stall_state", 32'({busy_o, flash_valid_o, word_valid_o}), 32'h5);
    check("stall_head", word_data_o, model_word(24'h000200, 0));
    rdy_mode = 0;
    finish_cmd("stall", 6);
    verify("stall", 24'h000200, 6);

    // Reset after the second byte of the second word.
    rdy_mode = 2;
    start_cmd(24'h000400, 3);
    cyc = 0;
    while (req_q.size() < 6 && cyc < 2000) begin
      step();
      cyc++;
    end
    @(posedge clock);
    #2;
    check("rst_pre_state", 32'({busy_o, word_valid_o}), 32'h3);
    reset_n = 1'b0;
    #1;
    check("rst_async_ctrl", 32'({busy_o, done_o, flash_valid_o, word_valid_o}), 32'h0);
    check("rst_async_addr", 32'(flash_addr_o), 32'h0);
    check("rst_async_data", word_data_o, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("rst_quiet", 32'({busy_o, flash_valid_o, word_valid_o}), 32'h0);
    run_cmd("post_rst", 24'h000800, 2, 0, 1'b0, 1);

    // Randomized commands.
    for (int k = 0; k < 8; k++) begin
      raddr = 24'($urandom);
      rn    = $urandom_range(7, 1);
      run_cmd($sformatf("rnd%0d", k), raddr, rn, 1, (k % 2) == 1, $urandom_range(3, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
